// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous display buffer.
// Latency: LOAD reaches the display at the next frame boundary; FRAME is registered (1 cycle).
// Backpressure: none; LOAD is always accepted. Optional macro SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GAP_CYC  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic [3:0]  DOTS,
    input  logic        LOAD,
    input  logic        BLANK,
    output logic [3:0]  DIGIT,
    output logic        EN,
    output logic        DOT,
    output logic [3:0]  nDIG,
    output logic        FRAME
);

    localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     cnt;
    logic [1:0]      idx;
    logic [3:0][3:0] disp;
    logic [3:0]      dots_disp;
    logic [15:0]     shadow;
    logic [3:0]      shadow_dots;
    logic            pend;
    logic            slot_end;
    logic            boundary;

    assign slot_end = (cnt == SLOT_LAST);
    assign boundary = (state == SHOW) && slot_end && (idx == 2'd3);

`ifdef SEG7_LZB_EN
    // lz[i]: digit i and every digit above it are zero; digit 0 always shows.
    logic [3:0] lz;
    assign lz[3] = (disp[3] == 4'd0);
    assign lz[2] = lz[3] && (disp[2] == 4'd0);
    assign lz[1] = lz[2] && (disp[1] == 4'd0);
    assign lz[0] = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= GAP;
            cnt         <= 16'd0;
            idx         <= 2'd0;
            disp        <= '0;
            dots_disp   <= 4'd0;
            shadow      <= 16'd0;
            shadow_dots <= 4'd0;
            pend        <= 1'b0;
            FRAME       <= 1'b0;
        end else begin
            state <= state_nxt;
            FRAME <= boundary;
            if (slot_end) begin
                cnt <= 16'd0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (LOAD) begin
                shadow      <= DATA;
                shadow_dots <= DOTS;
            end
            // A LOAD coinciding with the boundary bypasses the shadow so it is not lost a frame.
            if (boundary) begin
                if (LOAD) begin
                    disp      <= DATA;
                    dots_disp <= DOTS;
                end else if (pend) begin
                    disp      <= shadow;
                    dots_disp <= shadow_dots;
                end
                pend <= 1'b0;
            end else if (LOAD) begin
                pend <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        nDIG      = 4'b1111;
        EN        = 1'b0;
        DIGIT     = disp[idx];
        DOT       = dots_disp[idx];
        case (state)
            GAP: begin
                if (cnt == GAP_LAST) state_nxt = SHOW;
            end
            SHOW: begin
                if (slot_end) state_nxt = GAP;
                if (!BLANK) begin
                    nDIG = ~(4'b0001 << idx);
`ifdef SEG7_LZB_EN
                    EN   = ~lz[idx];
`else
                    EN   = 1'b1;
`endif
                end
            end
            default: state_nxt = GAP;
        endcase
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=8, GAP_CYC=2 (32-cycle frame).
module tb_seg7_scan_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] DATA;
    logic [3:0]  DOTS;
    logic        LOAD;
    logic        BLANK;
    logic [3:0]  DIGIT;
    logic        EN;
    logic        DOT;
    logic [3:0]  nDIG;
    logic        FRAME;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] exp_disp = 16'd0;
    logic [3:0]  exp_dots = 4'd0;
    logic        bl       = 1'b0;

    seg7_scan_ctrl #(.SCAN_DIV(8), .GAP_CYC(2)) dut (
        .CLK(CLK), .RST(RST), .DATA(DATA), .DOTS(DOTS), .LOAD(LOAD), .BLANK(BLANK),
        .DIGIT(DIGIT), .EN(EN), .DOT(DOT), .nDIG(nDIG), .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic logic lz_sup(input int slot, input logic [15:0] d);
`ifdef SEG7_LZB_EN
        case (slot)
            3:       return d[15:12] == 4'd0;
            2:       return d[15:8] == 8'd0;
            1:       return d[15:4] == 12'd0;
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_ndig",  16'(nDIG),  16'h000F);
        chk("rst_en",    16'(EN),    16'h0000);
        chk("rst_digit", 16'(DIGIT), 16'h0000);
        chk("rst_dot",   16'(DOT),   16'h0000);
        chk("rst_frame", 16'(FRAME), 16'h0000);
    endtask

    // Expected outputs from the cycle position: cyc counts edges since reset release.
    task automatic check_all();
        int         slot;
        int         pos;
        logic       show;
        logic [3:0] e_ndig;
        logic       e_en;
        logic       e_frame;
        slot    = (cyc / 8) % 4;
        pos     = cyc % 8;
        show    = (pos >= 2);
        e_ndig  = (show && !bl) ? ~(4'b0001 << slot) : 4'b1111;
        e_en    = show && !bl && !lz_sup(slot, exp_disp);
        e_frame = (cyc % 32 == 0) && (cyc > 0);
        chk("ndig",  16'(nDIG),  16'(e_ndig));
        chk("en",    16'(EN),    16'(e_en));
        chk("digit", 16'(DIGIT), 16'(exp_disp[slot*4 +: 4]));
        chk("dot",   16'(DOT),   16'(exp_dots[slot]));
        chk("frame", 16'(FRAME), 16'(e_frame));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            cyc++;
            check_all();
        end
    endtask

    initial begin
        RST = 1'b1; DATA = 16'd0; DOTS = 4'd0; LOAD = 1'b0; BLANK = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        RST = 1'b0;
        cyc = 0;

        // Two full frames of plain scanning.
        run(64);

        // LOAD in slot 1: held back until the next frame boundary.
        run(10);
        LOAD = 1'b1; DATA = 16'h1234; DOTS = 4'b0100;
        run(1);
        LOAD = 1'b0; DATA = 16'h0000; DOTS = 4'b0000;
        run(20);
        exp_disp = 16'h1234; exp_dots = 4'b0100;
        run(32);

        // LOAD in the boundary cycle itself: visible in the very next frame.
        LOAD = 1'b1; DATA = 16'hABCD; DOTS = 4'b0000;
        exp_disp = 16'hABCD; exp_dots = 4'b0000;
        run(1);
        LOAD = 1'b0;
        run(2);

        // Two LOADs in one frame: last one wins.
        LOAD = 1'b1; DATA = 16'h5555; DOTS = 4'b1111;
        run(1);
        LOAD = 1'b0;
        run(9);
        LOAD = 1'b1; DATA = 16'h9876; DOTS = 4'b0011;
        run(1);
        LOAD = 1'b0;
        run(18);
        exp_disp = 16'h9876; exp_dots = 4'b0011;
        run(1);

        // BLANK for 40 cycles across a frame boundary.
        BLANK = 1'b1; bl = 1'b1;
        run(40);
        BLANK = 1'b0; bl = 1'b0;

        // Leading zeros.
        LOAD = 1'b1; DATA = 16'h0070; DOTS = 4'b0000;
        run(1);
        LOAD = 1'b0;
        run(22);
        exp_disp = 16'h0070; exp_dots = 4'b0000;
        run(53);

        // Reset mid-SHOW of slot 2, colliding with a LOAD.
        RST = 1'b1; LOAD = 1'b1; DATA = 16'hFFFF; DOTS = 4'b1111;
        tick();
        check_reset_outputs();
        RST = 1'b0; LOAD = 1'b0;
        cyc = 0;
        exp_disp = 16'h0000; exp_dots = 4'b0000;
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
